expr_share_arbiter: RTL and testbench

EXPR_SHARE_ARBITER -- requirements
Module: expr_share_arbiter

---
 rtl/expr_share_arbiter.sv | 101 ++++++++++
 tb/tb_expr_share_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/expr_share_arbiter.sv
// Two-requester round-robin front end for a shared combinational datapath.
// Operands are registered into dp_ops; the datapath result is captured after LAT settle cycles.
module expr_share_arbiter #(
  parameter int unsigned OPW  = 60,
  parameter int unsigned RESW = 90,
  parameter int unsigned LAT  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_ops,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_ops,
  output logic [OPW-1:0]  dp_ops,
  input  logic [RESW-1:0] dp_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [RESW-1:0] rsp_data,
  output logic            busy,
  output logic [15:0]     done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t      state;
  logic        last_grant;
  logic [1:0]  wait_cnt;
  logic        grant;
  logic        any_valid;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = ~req0_valid;
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state == IDLE) begin
      req0_ready = req0_valid & ~grant;
      req1_ready = req1_valid & grant;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dp_ops     <= '0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      done_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            dp_ops     <= grant ? req1_ops : req0_ops;
            rsp_id     <= grant;
            last_grant <= grant;
            wait_cnt   <= 2'(LAT);
            state      <= EVAL;
          end
        end
        EVAL: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            rsp_data  <= dp_res;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_share_arbiter.sv
// Scoreboard bench: one LAT=0 and one LAT=3 instance share stimulus; each has its own reference model.
module tb_expr_share_arbiter;

  localparam int unsigned OPW  = 60;
  localparam int unsigned RESW = 90;

  typedef struct packed {
    logic           id;
    logic [OPW-1:0] ops;
  } txn_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            v0, v1, rsp_ready;
  logic [OPW-1:0]  ops0, ops1;
  logic            r0 [2];
  logic            r1 [2];
  logic            rsp_valid [2];
  logic            rsp_id [2];
  logic            busy [2];
  logic [OPW-1:0]  dp_ops [2];
  logic [RESW-1:0] dp_res [2];
  logic [RESW-1:0] rsp_data [2];
  logic [15:0]     done_cnt [2];
  int unsigned     cyc = 0;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference datapath: y = {a^b, a*b} with a/b the two 30-bit halves.
  function automatic logic [RESW-1:0] f(input logic [OPW-1:0] o);
    logic [29:0] a, b;
    a = o[59:30];
    b = o[29:0];
    return {a ^ b, 60'(a) * 60'(b)};
  endfunction

  task automatic chk(input string tag, input logic [RESW-1:0] got, input logic [RESW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int unsigned L = (k == 0) ? 0 : 3;

    // Folding the cycle count into the result pins down the capture edge.
    assign dp_res[k] = f(dp_ops[k]) ^ RESW'(cyc);

    expr_share_arbiter #(.OPW(OPW), .RESW(RESW), .LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_ready(r0[k]), .req0_ops(ops0),
      .req1_valid(v1), .req1_ready(r1[k]), .req1_ops(ops1),
      .dp_ops(dp_ops[k]), .dp_res(dp_res[k]),
      .rsp_valid(rsp_valid[k]), .rsp_ready(rsp_ready), .rsp_id(rsp_id[k]),
      .rsp_data(rsp_data[k]), .busy(busy[k]), .done_cnt(done_cnt[k])
    );

    txn_t           q[$];
    int             m_left = -1;
    logic           m_last = 1'b1;
    logic [15:0]    m_done = '0;
    logic [OPW-1:0] m_ops = '0;
    int unsigned    m_cap = 0;

    always @(negedge clk) begin
      logic g, acc;
      txn_t t;
      if (reset) begin
        chk($sformatf("d%0d ready0 in reset", k), RESW'(r0[k]), '0);
        chk($sformatf("d%0d ready1 in reset", k), RESW'(r1[k]), '0);
        m_left = -1;
        m_last = 1'b1;
        m_done = '0;
        m_ops  = '0;
        q.delete();
      end else begin
        acc = 1'b0;
        g   = 1'b0;
        if (m_left < 0 && (v0 || v1)) begin
          acc = 1'b1;
          g   = (v0 && v1) ? ~m_last : ~v0;
        end
        chk($sformatf("d%0d ready0", k), RESW'(r0[k]), RESW'(acc & ~g));
        chk($sformatf("d%0d ready1", k), RESW'(r1[k]), RESW'(acc & g));
        chk($sformatf("d%0d busy", k), RESW'(busy[k]), RESW'(m_left >= 0));
        chk($sformatf("d%0d rsp_valid", k), RESW'(rsp_valid[k]), RESW'(m_left == 0));
        chk($sformatf("d%0d dp_ops", k), RESW'(dp_ops[k]), RESW'(m_ops));
        chk($sformatf("d%0d done_cnt", k), RESW'(done_cnt[k]), RESW'(m_done));
        if (m_left == 0) begin
          chk($sformatf("d%0d sb depth", k), RESW'(q.size()), RESW'(1));
          if (q.size() > 0) begin
            t = q[0];
            chk($sformatf("d%0d rsp_id", k), RESW'(rsp_id[k]), RESW'(t.id));
            chk($sformatf("d%0d rsp_data", k), rsp_data[k], f(t.ops) ^ RESW'(m_cap));
            if (rsp_ready) begin
              void'(q.pop_front());
              m_done = m_done + 16'd1;
              m_left = -1;
            end
          end
        end else if (m_left > 0) begin
          if (m_left == 1) m_cap = cyc;
          m_left = m_left - 1;
        end
        if (acc) begin
          t.id  = g;
          t.ops = g ? ops1 : ops0;
          q.push_back(t);
          m_last = g;
          m_ops  = t.ops;
          m_left = int'(L) + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    ops0 = '0; ops1 = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d reset rsp_data", i), rsp_data[i], '0);
      chk($sformatf("d%0d reset rsp_id", i), RESW'(rsp_id[i]), '0);
    end

    // Single request with operand 1.
    tick();
    v0 = 1'b1; ops0 = OPW'(1);
    tick();
    v0 = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("d%0d single done_cnt", i), RESW'(done_cnt[i]), RESW'(1));

    // Continuous tie: requesters alternate.
    v0 = 1'b1; v1 = 1'b1;
    repeat (24) begin
      ops0 = OPW'({$urandom, $urandom});
      ops1 = OPW'({$urandom, $urandom});
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (8) tick();

    // Backpressure; requester 1 flickers valid while the block is busy.
    rsp_ready = 1'b0;
    v0 = 1'b1; ops0 = OPW'({$urandom, $urandom});
    tick();
    v0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      v1 = i[0];
      tick();
    end
    v1 = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) tick();

    // Reset one cycle into EVAL aborts the request.
    v0 = 1'b1; v1 = 1'b1;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d post-reset tie ready0", i), RESW'(r0[i]), RESW'(1));
      chk($sformatf("d%0d post-reset done_cnt", i), RESW'(done_cnt[i]), '0);
    end
    tick();
    v0 = 1'b0; v1 = 1'b0;
    repeat (8) tick();

    // Random traffic.
    repeat (400) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
      ops0 = OPW'({$urandom, $urandom});
      ops1 = OPW'({$urandom, $urandom});
      tick();
    end
    v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
